// File: rtl/cmp_seq_pkg.sv
// Shared types and constants for the nibble-serial magnitude comparator.
package cmp_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Cascade / result triple, ordered as the 74HC85 outputs.
  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } casc_t;

endpackage

// File: rtl/comparator_4.sv
// 74HC85-equivalent 4-bit cascadable magnitude comparator (combinational).
module comparator_4
  import cmp_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                igt_i,
  input  logic                ilt_i,
  input  logic                ieq_i,
  output logic                fgt_o,
  output logic                flt_o,
  output logic                feq_o
);

  // Unequal nibbles decide on their own; equal nibbles follow the HC85 cascade table.
  always_comb begin
    fgt_o = 1'b0;
    flt_o = 1'b0;
    feq_o = 1'b0;
    if (a_i > b_i) begin
      fgt_o = 1'b1;
    end else if (a_i < b_i) begin
      flt_o = 1'b1;
    end else begin
      feq_o = ieq_i;
      fgt_o = ~ieq_i & ~ilt_i;
      flt_o = ~ieq_i & ~igt_i;
    end
  end

endmodule

// File: rtl/comparator_seq_ctrl.sv
// Time-multiplexed WIDTH-bit magnitude comparator: one comparator_4 walked over
// the operand nibbles LSB first, cascade fed back through a register.
// Optional feature macro: CMP_SEQ_ABORT_EN adds an 'abort' input.
module comparator_seq_ctrl
  import cmp_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Igt,
  input  logic             Ilt,
  input  logic             Ieq,
`ifdef CMP_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             Fgt,
  output logic             Flt,
  output logic             Feq
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  casc_t              cas_q, cas_d;
  casc_t              res_q, res_d;
  casc_t              cmp_c;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               abort_c;

`ifdef CMP_SEQ_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  comparator_4 u_cmp (
    .a_i   (a_q[NIBBLE_W*idx_q +: NIBBLE_W]),
    .b_i   (b_q[NIBBLE_W*idx_q +: NIBBLE_W]),
    .igt_i (cas_q.gt),
    .ilt_i (cas_q.lt),
    .ieq_i (cas_q.eq),
    .fgt_o (cmp_c.gt),
    .flt_o (cmp_c.lt),
    .feq_o (cmp_c.eq)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: start only in IDLE, last nibble ends RUN, abort overrides RUN/DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (abort_c)                state_d = IDLE;
        else if (idx_q == IDX_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath/output next values: capture, ripple one nibble per cycle, publish.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    cas_d  = cas_q;
    idx_d  = idx_q;
    res_d  = res_q;
    done_d = 1'b0;
    busy_d = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = A;
          b_d   = B;
          cas_d = '{gt: Igt, lt: Ilt, eq: Ieq};
          idx_d = '0;
        end
      end
      RUN: begin
        if (!abort_c) begin
          cas_d = cmp_c;
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (!abort_c) begin
          res_d  = cas_q;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      cas_q  <= '0;
      res_q  <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      cas_q  <= cas_d;
      res_q  <= res_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Fgt  = res_q.gt;
  assign Flt  = res_q.lt;
  assign Feq  = res_q.eq;

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// Self-checking bench for comparator_seq_ctrl: directed cases plus random traffic
// checked every cycle against a transaction-level model.
module tb_comparator_seq_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Igt = 1'b0, Ilt = 1'b0, Ieq = 1'b0;
`ifdef CMP_SEQ_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic         busy, done, Fgt, Flt, Feq;

  int n_cmp = 0;
  int n_bad = 0;

  comparator_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Igt   (Igt),
    .Ilt   (Ilt),
    .Ieq   (Ieq),
`ifdef CMP_SEQ_ABORT_EN
    .abort (abort),
`endif
    .busy  (busy),
    .done  (done),
    .Fgt   (Fgt),
    .Flt   (Flt),
    .Feq   (Feq)
  );

  always #5 clk = ~clk;

  // Reference result {gt,lt,eq}: full-width compare decides when unequal;
  // when equal, the cascade input passes through NIB equal stages of the HC85 table.
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] c);
    logic [2:0] r;
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    r = c;
    for (int i = 0; i < NIB; i++)
      r = r[0] ? 3'b001 : {~r[1], ~r[2], 1'b0};
    return r;
  endfunction

  // Transaction model: an accepted request completes NIB+1 edges later unless aborted/reset.
  bit         m_pend = 0;
  bit         m_done = 0;
  logic [2:0] m_f = '0;
  logic [2:0] m_res = '0;
  int         m_acc = 0;
  int         cyc = 0;
  logic       ab_now;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 0;
      m_done = 0;
      m_f    = '0;
    end else begin
      cyc++;
      m_done = 0;
`ifdef CMP_SEQ_ABORT_EN
      ab_now = abort;
`else
      ab_now = 1'b0;
`endif
      if (m_pend && ab_now) begin
        m_pend = 0;
      end else if (m_pend && cyc == m_acc + NIB + 1) begin
        m_done = 1;
        m_f    = m_res;
        m_pend = 0;
      end else if (!m_pend && start) begin
        m_pend = 1;
        m_acc  = cyc;
        m_res  = ref_cmp(A, B, {Igt, Ilt, Ieq});
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Advance one cycle and compare all outputs against the model.
  task automatic tick();
    @(negedge clk);
    n_cmp++;
    if ({busy, done, Fgt, Flt, Feq} !== {m_pend, m_done, m_f}) begin
      n_bad++;
      $display("FAIL cycle_check t=%0t got busy,done,F=%b expected %b", $time,
               {busy, done, Fgt, Flt, Feq}, {m_pend, m_done, m_f});
    end
  endtask

  // One full operation with literal expectations on latency and result.
  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] c, input logic [2:0] exp);
    int n;
    A = a; B = b; {Igt, Ilt, Ieq} = c; start = 1'b1;
    tick();
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); {Igt, Ilt, Ieq} = 3'($urandom);
    chk({nm, "_busy"}, int'(busy), 1);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, n, 5);
    chk({nm, "_result"}, int'({Fgt, Flt, Feq}), int'(exp));
    tick();
  endtask

  initial begin
    int dones;
    int done_at;
    logic [W-1:0] r;

    repeat (2) tick();
    chk("reset_outputs", int'({busy, done, Fgt, Flt, Feq}), 0);
    rst = 1'b0;
    tick();

    chk("model_pin_equal", int'(ref_cmp(16'h1234, 16'h1234, 3'b001)), 1);
    chk("model_pin_nocasc", int'(ref_cmp(16'h0000, 16'h0000, 3'b000)), 0);

    run_op("eq_1234", 16'h1234, 16'h1234, 3'b001, 3'b001);
    run_op("gt_msb", 16'h8000, 16'h7FFF, 3'b001, 3'b100);
    run_op("lt_lsb", 16'h0012, 16'h0013, 3'b001, 3'b010);
    run_op("casc_gt", 16'hFFFF, 16'hFFFF, 3'b100, 3'b100);
    run_op("casc_none", 16'h5A5A, 16'h5A5A, 3'b000, 3'b000);

    // Extra start pulses sampled at edges 2 and 5 must be ignored.
    A = 16'h00F0; B = 16'h0F00; {Igt, Ilt, Ieq} = 3'b001; start = 1'b1;
    tick();
    dones = 0; done_at = -1;
    for (int k = 1; k <= 12; k++) begin
      start = (k == 2 || k == 5);
      tick();
      if (done) begin
        dones++;
        if (done_at < 0) done_at = k;
      end
    end
    start = 1'b0;
    chk("busy_start_dones", dones, 1);
    chk("busy_start_done_at", done_at, 5);
    chk("busy_start_result", int'({Fgt, Flt, Feq}), 3'b010);

    // Reset during RUN: outputs clear immediately, no done follows.
    A = 16'hFFFF; B = 16'h0000; {Igt, Ilt, Ieq} = 3'b001; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", int'({busy, done, Fgt, Flt, Feq}), 0);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done) dones++;
    end
    chk("rst_mid_no_done", dones, 0);

`ifdef CMP_SEQ_ABORT_EN
    run_op("pre_abort", 16'h8000, 16'h7FFF, 3'b001, 3'b100);
    A = 16'h1234; B = 16'h1234; {Igt, Ilt, Ieq} = 3'b001; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy_low", int'(busy), 0);
    A = 16'h0012; B = 16'h0013; start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_restart_busy", int'(busy), 1);
    chk("abort_result_kept", int'({Fgt, Flt, Feq}), 3'b100);
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done) dones++;
    end
    chk("abort_restart_dones", dones, 1);
    chk("abort_restart_result", int'({Fgt, Flt, Feq}), 3'b010);
`endif

    // Random traffic: near-equal operands, all cascade codes, stray starts, rare abort/reset.
    for (int i = 0; i < 4000; i++) begin
      r = W'($urandom);
      A = r;
      case ($urandom % 4)
        0: B = r;
        1: B = r ^ (W'($urandom_range(1, 15)) << (4 * $urandom_range(0, NIB - 1)));
        default: B = W'($urandom);
      endcase
      {Igt, Ilt, Ieq} = 3'($urandom);
      start = ($urandom % 3 == 0);
`ifdef CMP_SEQ_ABORT_EN
      abort = ($urandom % 24 == 0);
`endif
      rst = ($urandom % 700 == 0);
      tick();
    end
    start = 1'b0;
    rst = 1'b0;
`ifdef CMP_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
